// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, write-back state encoding
// and the butterfly address helper used by read and write sides.
package fft_pkg;

  localparam int FFT_SIZE = 4;
  localparam int N_HALF = 2 ** (FFT_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_TOP = 2'd1,
    WR_BOT = 2'd2
  } wb_state_t;

  // {top, bot} memory addresses of butterfly k in stage s
  function automatic logic [2*FFT_SIZE-1:0] bf_addr(
    input logic [FFT_SIZE-1:0] k,
    input logic [3:0]          s
  );
    logic [FFT_SIZE-1:0] span;
    logic [FFT_SIZE-1:0] top;
    span = FFT_SIZE'(1) << (s - 4'd1);
    top  = ((k >> (s - 4'd1)) << s)
         | (k & (span - FFT_SIZE'(1)));
    return {top, top + span};
  endfunction

endpackage

// File: rtl/butterfly_writeback_fifo.sv
// bf_pair_fifo: 2-deep buffer of butterfly result pairs,
// exposing the head entry and the one queued behind it.
module bf_pair_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [W-1:0] o_next,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push
               && ((r_cnt != 2'd2) || w_pop);

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_next  = r_mem[~r_rp];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/butterfly_writeback.sv
// butterfly_writeback: captures butterfly result pairs and
// serialises them into two in-place memory writes per pair.
module butterfly_writeback
  import fft_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int SIZE      = FFT_SIZE,
  parameter int SCALE     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  stage_FFT,
  input  logic                        en,
  input  logic signed [bit_width-1:0] xin1,
  input  logic signed [bit_width-1:0] yin1,
  input  logic signed [bit_width-1:0] xin2,
  input  logic signed [bit_width-1:0] yin2,
  output logic                        in_ready,
  input  logic                        wr_ready,
  output logic                        wr_en,
  output logic [SIZE-1:0]             wr_addr,
  output logic signed [bit_width-1:0] wr_re,
  output logic signed [bit_width-1:0] wr_im,
  output logic                        stage_done,
  output logic                        overflow_err
);

  localparam int KW = SIZE - 1;

  typedef struct packed {
    logic                        last;
    logic [SIZE-1:0]             top;
    logic [SIZE-1:0]             bot;
    logic signed [bit_width-1:0] x1;
    logic signed [bit_width-1:0] y1;
    logic signed [bit_width-1:0] x2;
    logic signed [bit_width-1:0] y2;
  } ent_t;

  localparam int EW = $bits(ent_t);

  wb_state_t         r_state;
  logic [KW-1:0]     r_k;
  logic [3:0]        r_stage;
  logic              r_last;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;
  logic              w_accept;
  logic              w_pop;
  logic [3:0]        w_s_clamp;
  logic [3:0]        w_s;
  logic [2*SIZE-1:0] w_addr;
  ent_t              w_ent;
  ent_t              w_head;
  ent_t              w_next;
  ent_t              w_src;

  function automatic logic signed [bit_width-1:0] scl(
    input logic signed [bit_width-1:0] v
  );
    return (SCALE != 0) ? (v >>> 1) : v;
  endfunction

  assign in_ready  = rst_n & ~w_full;
  assign w_accept  = en & in_ready;
  assign w_pop     = (r_state == WR_BOT) & wr_ready;
  assign w_s_clamp =
    (stage_FFT == 4'd0 || stage_FFT > 4'(SIZE))
    ? 4'(SIZE) : stage_FFT;
  assign w_s    = (r_k == '0) ? w_s_clamp : r_stage;
  assign w_addr = bf_addr({1'b0, r_k}, w_s);
  assign w_src  =
    (r_state == WR_BOT && w_count == 2'd2)
    ? w_next : w_head;

  // build the queued entry: addresses and scaled data
  always_comb begin
    w_ent.last = (r_k == KW'(N_HALF - 1));
    w_ent.top  = w_addr[2*SIZE-1:SIZE];
    w_ent.bot  = w_addr[SIZE-1:0];
    w_ent.x1   = scl(xin1);
    w_ent.y1   = scl(yin1);
    w_ent.x2   = scl(xin2);
    w_ent.y2   = scl(yin2);
  end

  bf_pair_fifo #(
    .W(EW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_accept),
    .i_data (w_ent),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_next (w_next),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // pair counter, stage latch and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_stage      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_k <= r_k + KW'(1);
        if (r_k == '0) begin
          r_stage <= w_s_clamp;
        end
      end
      if (en && !in_ready) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // write sequencer: top then bottom write per pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_re      <= '0;
      wr_im      <= '0;
      stage_done <= 1'b0;
    end else begin
      stage_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state <= WR_TOP;
            wr_en   <= 1'b1;
            wr_addr <= w_src.top;
            wr_re   <= w_src.x1;
            wr_im   <= w_src.y1;
          end
        end
        WR_TOP: begin
          if (wr_ready) begin
            r_state <= WR_BOT;
            r_last  <= w_src.last;
            wr_addr <= w_src.bot;
            wr_re   <= w_src.x2;
            wr_im   <= w_src.y2;
          end
        end
        WR_BOT: begin
          if (wr_ready) begin
            stage_done <= r_last;
            if (w_count == 2'd2) begin
              r_state <= WR_TOP;
              wr_addr <= w_src.top;
              wr_re   <= w_src.x1;
              wr_im   <= w_src.y1;
            end else begin
              r_state <= IDLE;
              wr_en   <= 1'b0;
              wr_addr <= '0;
              wr_re   <= '0;
              wr_im   <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/butterfly_writeback.md
Name: butterfly_writeback

Overview:
Consumer end of the radix-2 butterfly adder. It captures each butterfly result pair (sum and difference outputs) when the adder's enable fires, optionally scales it, and serialises it into two in-place memory writes at addresses generated per FFT stage. It sits between the butterfly adder and the single-write-port working memory, and it reports stage completion to the FFT controller.

Parameters:
bit_width, 16, width of each real/imag sample
SIZE, 4, log2(N); number of FFT stages (N = 2**SIZE points)
SCALE, 1, 1 = arithmetic shift right by 1 (truncate) on every stored sample; 0 = pass through

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
stage_FFT  in  4  current stage, 1..SIZE
en  in  1  butterfly result valid
xin1  in  bit_width  signed real of sum output (top)
yin1  in  bit_width  signed imag of sum output (top)
xin2  in  bit_width  signed real of difference output (bottom)
yin2  in  bit_width  signed imag of difference output (bottom)
in_ready  out  1  a pair can be accepted this cycle
wr_ready  in  1  memory accepts a write this cycle
wr_en  out  1  write strobe
wr_addr  out  SIZE  write address
wr_re  out  bit_width  write data, real
wr_im  out  bit_width  write data, imag
stage_done  out  1  one-cycle pulse after the last write of a stage
overflow_err  out  1  sticky: en asserted while in_ready low

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). On reset all outputs are 0, the FIFO is empty, the butterfly counter k is 0, and the FSM is in IDLE.
- Input buffer: a 2-entry FIFO of {x1,y1,x2,y2,top,bot}. in_ready = FIFO not full. A pair is accepted on en && in_ready. Accept and pop may occur in the same cycle, including when the FIFO is full.
- Address generation at accept: s = stage_FFT, span = 2**(s-1), top = ((k >> (s-1)) << s) | (k & (span-1)), bot = top + span.
  - k increments per accepted pair and wraps from 2**(SIZE-1)-1 to 0.
  - stage_FFT is latched at the first accept of a stage (k = 0) and is held until the wrap. Mid-stage changes are ignored.
- Scaling: applied at accept. With SCALE=1, data is shifted arithmetically right by 1 (floor, for example -3 becomes -2). With SCALE=0, data passes through unchanged.
- FSM states: IDLE, WR_TOP, WR_BOT.
  - IDLE to WR_TOP when the FIFO is not empty.
  - WR_TOP: wr_en=1, wr_addr=top, data = (x1,y1). When wr_ready is high, go to WR_BOT.
  - WR_BOT: wr_en=1, wr_addr=bot, data = (x2,y2). When wr_ready is high, pop the FIFO and go to WR_TOP if the FIFO still holds an entry, otherwise go to IDLE.
  - While wr_ready is low, wr_en, wr_addr and wr_re/wr_im hold stable.
- Latency: with the FIFO empty and wr_ready=1, a pair accepted at edge t presents its top write at t+1 and its bottom write at t+2. Sustained throughput is one pair per 2 cycles, so in_ready de-asserts after 2 back-to-back accepts without drain.
- stage_done: registered pulse in the cycle after the bottom write of the pair carrying the last k (2**(SIZE-1)-1) completes.
- overflow_err: sets on en && !in_ready. The offending pair is dropped and k does not advance. Cleared only by reset.
- stage_FFT outside 1..SIZE at first accept: treated as SIZE (clamped).
- Reset mid-operation: any in-flight write is abandoned, wr_en drops immediately, and k returns to 0.

Decomposition:
- Shared package fft_pkg holds:
  - the constant N_HALF = 2**(SIZE-1);
  - the FSM state encoding (IDLE=0, WR_TOP=1, WR_BOT=2);
  - the function bf_addr(k, s) returning {top, bot}, so the read-side address generator uses the same function.
- One sub-module, bf_pair_fifo (2-deep, parameterised width), holds the buffer. The FSM, counter and scaling stay in the top module.

Test Plan:
- Stage 1, SCALE=0, 8 pairs with en every other cycle and wr_ready=1 -> writes to addresses (0,1),(2,3)..(14,15). The pair with k=3 writes (x1,y1)=(100,-50) to address 6 and (x2,y2) to 7. stage_done pulses once after the write to 15.
- Stage 3 then stage 4, SCALE=1 -> in stage 3, k=5 writes to 9 then 13. In stage 4, k=5 writes to 5 then 13. Input x1=-3 is written as -2, and 32767 as 16383.
- en held high 4 cycles with wr_ready=0 -> first 2 pairs accepted, then in_ready=0 and overflow_err=1. The 3rd pair is dropped and k=2 afterwards.
- wr_ready toggling 1,0,0,1 during WR_TOP -> wr_addr and wr_re stay stable while stalled, and no write is duplicated or lost.
- stage_FFT changed from 2 to 3 at k=4 -> remaining stage-2 addresses are still used. stage 3 addressing takes effect after the wrap.
- rst_n asserted in WR_BOT with 1 entry queued -> wr_en=0 immediately. After release the next pair writes to address 0 (k=0), and overflow_err=0.
